// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory access controller
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LW  = 3'd4;

    localparam logic [3:0] WSTRB_LOAD    = 4'b0000;
    localparam logic [3:0] WSTRB_HALF_LO = 4'b0011;
    localparam logic [3:0] WSTRB_HALF_HI = 4'b1100;
    localparam logic [3:0] WSTRB_WORD    = 4'b1111;

    // Halfword ops must sit on an even byte, word ops on a word boundary.
    function automatic logic is_misaligned(input logic [3:0] wen, input logic [2:0] ltype,
                                           input logic [1:0] off);
        logic half;
        logic word;
        if (wen == WSTRB_LOAD) begin
            half = (ltype == LT_LH) || (ltype == LT_LHU);
            word = (ltype == LT_LW);
        end else begin
            half = (wen == WSTRB_HALF_LO) || (wen == WSTRB_HALF_HI);
            word = (wen == WSTRB_WORD);
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects and sign/zero-extends the loaded byte/half/word
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  ltype,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane and half lane, then extend by load type.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (ltype)
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'h000000, byte_sel};
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer over split addr_ok/data_ok SRAM (option: DMEM_ALIGN_CHECK_EN)
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_ltype,
    input  logic              flush,
    input  logic              hold,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [3:0]        sram_wstrb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_addr_ok,
    input  logic              sram_data_ok,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              stallreq,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign
);

    state_t            state;
    state_t            state_nx;
    logic              discard;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        ltype_q;
    logic [DATA_W-1:0] ext_data;
    logic              accept;
    logic              capture;
    logic              set_discard;
    logic              clr_discard;
    logic              fault;

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_q;
    assign fault    = is_misaligned(req_wen, req_ltype, req_addr[1:0]);
    assign misalign = misalign_q && (state == ST_DONE);
`else
    assign fault    = 1'b0;
    assign misalign = 1'b0;
`endif

    assign sram_req   = (state == ST_REQ);
    assign sram_wr    = (wen_q != WSTRB_LOAD);
    assign sram_wstrb = wen_q;
    assign sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign sram_wdata = wdata_q;
    assign resp_valid = (state == ST_DONE);

    load_extend u_load_extend (
        .rdata  (sram_rdata),
        .offset (addr_q[1:0]),
        .ltype  (ltype_q),
        .data   (ext_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Next state, stall request and datapath strobes; a flushed op already
    // accepted by the SRAM is drained in WAIT with the stall released.
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        capture     = 1'b0;
        set_discard = 1'b0;
        clr_discard = 1'b0;
        stallreq    = 1'b0;
        case (state)
            ST_IDLE: begin
                stallreq = req_valid;
                if (req_valid && !flush) begin
                    accept   = 1'b1;
                    state_nx = fault ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stallreq = 1'b1;
                if (sram_addr_ok) begin
                    if (flush) begin
                        if (sram_data_ok) begin
                            state_nx = ST_IDLE;
                        end else begin
                            set_discard = 1'b1;
                            state_nx    = ST_WAIT;
                        end
                    end else if (sram_data_ok) begin
                        capture  = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end else if (flush) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stallreq = !discard;
                if (sram_data_ok) begin
                    if (discard || flush) begin
                        clr_discard = 1'b1;
                        state_nx    = ST_IDLE;
                    end else begin
                        capture  = 1'b1;
                        state_nx = ST_DONE;
                    end
                end else if (flush) begin
                    set_discard = 1'b1;
                end
            end
            default: begin
                if (flush || !hold) state_nx = ST_IDLE;
            end
        endcase
    end

    // Request capture, response capture (stores return zero) and discard flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            ltype_q    <= '0;
            resp_rdata <= '0;
            discard    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                wen_q      <= req_wen;
                wdata_q    <= req_wdata;
                ltype_q    <= req_ltype;
                resp_rdata <= '0;
            end
            if (capture) resp_rdata <= (wen_q == WSTRB_LOAD) ? ext_data : '0;
            if (clr_discard)      discard <= 1'b0;
            else if (set_discard) discard <= 1'b1;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Fault flag is set when a misaligned op is accepted and dropped on leaving DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          misalign_q <= 1'b0;
        else if (accept)                                   misalign_q <= fault;
        else if (state == ST_DONE && state_nx != ST_DONE)  misalign_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_wen = 4'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_ltype = 3'd0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        sram_req;
    logic        sram_wr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok = 1'b0;
    logic        sram_data_ok = 1'b0;
    logic [31:0] sram_rdata = 32'h0;
    logic        stallreq;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;

    int n_vec = 0;
    int n_bad = 0;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ltype(req_ltype), .flush(flush), .hold(hold),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
        .sram_rdata(sram_rdata), .stallreq(stallreq), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result: loads extract by arithmetic on the byte offset, stores yield zero.
    function automatic logic [31:0] model(input logic [3:0] wen, input logic [2:0] lt,
                                          input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int          off;
        off = int'(addr % 4);
        if (wen != 4'b0000) return 32'h0;
        case (lt)
            3'd0, 3'd1: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (lt == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd2, 3'd3: begin
                v = (rd >> (8 * (off / 2) * 2)) & 32'hFFFF;
                if (lt == 3'd2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal, 1: flush in first WAIT cycle, 2: flush while in DONE
    task automatic do_op(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] lt, input logic [31:0] rd,
                         input int aok, input int dok, input int hold_n, input int mode);
        int          stalls;
        logic [31:0] exp;
        stalls = 0;
        exp    = model(wen, lt, addr, rd);
        cyc_start();
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_ltype = lt;
        sram_addr_ok = 1'b0; sram_data_ok = 1'($urandom % 2); flush = 1'b0; hold = 1'b0;
        @(negedge clk);
        stalls += int'(stallreq);
        check("idle_no_req", sram_req, 1'b0);
        for (int k = 0; k <= aok; k++) begin
            cyc_start();
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wen = 4'($urandom);
            sram_addr_ok = (k == aok);
            sram_data_ok = (k == aok) && (dok == 0);
            sram_rdata   = sram_data_ok ? rd : $urandom;
            @(negedge clk);
            stalls += int'(stallreq);
            check("req_valid", sram_req, 1'b1);
            if (k == 0) begin
                check("req_addr", sram_addr, addr & 32'hFFFF_FFFC);
                check("req_wr", sram_wr, wen != 4'b0000);
                check("req_wstrb", sram_wstrb, wen);
                if (wen != 4'b0000) check("req_wdata", sram_wdata, wdata);
            end
        end
        for (int j = 1; j <= dok; j++) begin
            cyc_start();
            sram_addr_ok = 1'($urandom % 2);
            sram_data_ok = (j == dok);
            sram_rdata   = sram_data_ok ? rd : $urandom;
            flush        = (mode == 1) && (j == 1);
            @(negedge clk);
            stalls += int'(stallreq);
            check("wait_no_req", sram_req, 1'b0);
            check("wait_stall", stallreq, !((mode == 1) && (j > 1)));
        end
        if (mode == 1) begin
            cyc_start();
            sram_addr_ok = 1'b0; sram_data_ok = 1'b0; flush = 1'b0;
            @(negedge clk);
            check("discard_no_resp", resp_valid, 1'b0);
            check("discard_no_stall", stallreq, 1'b0);
        end else begin
            for (int h = 0; h <= hold_n; h++) begin
                cyc_start();
                sram_addr_ok = 1'($urandom % 2); sram_data_ok = 1'($urandom % 2); flush = 1'b0;
                req_valid = 1'($urandom % 2);
                hold  = (h < hold_n) || (mode == 2);
                flush = (mode == 2) && (h == hold_n);
                @(negedge clk);
                check("done_valid", resp_valid, 1'b1);
                check("done_rdata", resp_rdata, exp);
                check("done_stall", stallreq, 1'b0);
                check("done_misalign", misalign, 1'b0);
            end
            cyc_start();
            req_valid = 1'b0; hold = 1'b0; flush = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
            @(negedge clk);
            check("exit_valid", resp_valid, 1'b0);
            check("stall_cycles", stalls, 2 + aok + dok);
        end
    endtask

    initial begin
        logic [3:0]  wen;
        logic [2:0]  lt;
        logic [31:0] addr;
        int          kind;
        int          mode;
        int          dok;

        @(negedge clk);
        check("rst_sram_req", sram_req, 1'b0);
        check("rst_stall", stallreq, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_sram_addr", sram_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        do_op(4'b0000, 32'h100, 32'h0, 3'd4, 32'hDEADBEEF, 0, 0, 0, 0);
        do_op(4'b0000, 32'h203, 32'h0, 3'd0, 32'h80FFFFFF, 2, 3, 0, 0);
        do_op(4'b0000, 32'h203, 32'h0, 3'd1, 32'h80FFFFFF, 2, 3, 0, 0);
        do_op(4'b1100, 32'h302, 32'h12341234, 3'd0, 32'hFFFFFFFF, 1, 1, 0, 0);
        do_op(4'b0000, 32'h400, 32'h0, 3'd4, 32'h11111111, 0, 2, 0, 1);
        do_op(4'b0000, 32'h404, 32'h0, 3'd4, 32'h22222222, 1, 0, 0, 0);
        do_op(4'b0000, 32'h002, 32'h0, 3'd3, 32'hABCD0000, 0, 1, 3, 0);
        do_op(4'b0000, 32'h500, 32'h0, 3'd2, 32'h0000F00D, 0, 0, 1, 2);

        // flush before addr_ok withdraws the request
        cyc_start();
        req_valid = 1'b1; req_wen = 4'b0000; req_addr = 32'h600; req_ltype = 3'd4;
        cyc_start();
        req_valid = 1'b0; flush = 1'b1; sram_addr_ok = 1'b0;
        @(negedge clk);
        check("fl_req_pending", sram_req, 1'b1);
        cyc_start();
        flush = 1'b0;
        @(negedge clk);
        check("fl_req_dropped", sram_req, 1'b0);
        check("fl_req_no_resp", resp_valid, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        cyc_start();
        req_valid = 1'b1; req_wen = 4'b0000; req_addr = 32'h102; req_ltype = 3'd4;
        @(negedge clk);
        check("mis_stall", stallreq, 1'b1);
        cyc_start();
        req_valid = 1'b0;
        @(negedge clk);
        check("mis_no_req", sram_req, 1'b0);
        check("mis_valid", resp_valid, 1'b1);
        check("mis_flag", misalign, 1'b1);
        check("mis_rdata", resp_rdata, 32'h0);
        cyc_start();
        @(negedge clk);
        check("mis_clear", misalign, 1'b0);
        check("mis_exit", resp_valid, 1'b0);
`else
        do_op(4'b0000, 32'h102, 32'h0, 3'd4, 32'hCAFEF00D, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom % 8);
            addr = $urandom & 32'h0000_FFFF;
            lt   = 3'd0;
            wen  = 4'b0000;
            case (kind)
                0, 1: lt = 3'(kind);
                2, 3: begin lt = 3'(kind); addr[0] = 1'b0; end
                4:    begin lt = 3'd4; addr[1:0] = 2'b00; end
                5:    wen = 4'b0001 << addr[1:0];
                6:    begin addr[0] = 1'b0; wen = addr[1] ? 4'b1100 : 4'b0011; end
                default: begin addr[1:0] = 2'b00; wen = 4'b1111; end
            endcase
            mode = int'($urandom % 6);
            mode = (mode < 4) ? 0 : mode - 3;
            dok  = int'($urandom % 4);
            if (mode == 1 && dok == 0) dok = 1;
            do_op(wen, addr, $urandom, lt, $urandom, int'($urandom % 4), dok,
                  int'($urandom % 3), mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
